// File: rtl/change_dispenser_if.sv
// Signal bundle between a change-request source/coin hopper and the change dispenser.
`timescale 1ns/1ps
interface change_dispenser_if;
    logic       req_valid;
    logic [2:0] req_change;
    logic       req_ready;
    logic       hopper_ready;
    logic       out_nickel;
    logic       out_dime;
    logic       load_nickel;
    logic       load_dime;
    logic [3:0] nickel_cnt;
    logic [3:0] dime_cnt;
    logic       done;
    logic       err;
    logic       busy;

    modport master (
        output req_valid, req_change, hopper_ready, load_nickel, load_dime,
        input  req_ready, out_nickel, out_dime, nickel_cnt, dime_cnt, done, err, busy
    );

    modport slave (
        input  req_valid, req_change, hopper_ready, load_nickel, load_dime,
        output req_ready, out_nickel, out_dime, nickel_cnt, dime_cnt, done, err, busy
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy dime-first change dispenser with a refillable 4-bit nickel/dime inventory.
`timescale 1ns/1ps
module change_dispenser (
    input  logic clk,
    input  logic rst_n,
    change_dispenser_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DISPENSE, DONE, FAULT} state_t;

    state_t     state, state_next;
    logic [4:0] remaining, remaining_next, remaining_after;
    logic [3:0] nickel_cnt, dime_cnt;
    logic       accept, code_valid, feasible;
    logic       eject, dime_sel, eject_nickel, eject_dime;
    logic [2:0] half_code, dimes_used, nickels_needed;

    assign accept     = (state == IDLE) && bus.req_valid;
    assign code_valid = (bus.req_change <= 3'd4);

    // Feasibility in coin units: code counts nickels, so dimes take two units each.
    assign half_code      = {1'b0, bus.req_change[2:1]};
    assign dimes_used     = (dime_cnt < {1'b0, half_code}) ? dime_cnt[2:0] : half_code;
    assign nickels_needed = bus.req_change - {dimes_used[1:0], 1'b0};
    assign feasible       = ({1'b0, nickels_needed} <= nickel_cnt);

    assign dime_sel        = (remaining >= 5'd10) && (dime_cnt != 4'd0);
    assign eject           = (state == DISPENSE) && bus.hopper_ready;
    assign eject_dime      = eject && dime_sel;
    assign eject_nickel    = eject && !dime_sel;
    assign remaining_after = remaining - (dime_sel ? 5'd10 : 5'd5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= 5'd0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
        end
    end

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!code_valid || !feasible) begin
                        state_next     = FAULT;
                        remaining_next = 5'd0;
                    end else if (bus.req_change == 3'd0) begin
                        state_next     = DONE;
                        remaining_next = 5'd0;
                    end else begin
                        state_next     = DISPENSE;
                        remaining_next = ({2'b00, bus.req_change} << 2) + {2'b00, bus.req_change};
                    end
                end
            end
            DISPENSE: begin
                if (eject) begin
                    remaining_next = remaining_after;
                    if (remaining_after == 5'd0) begin
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            FAULT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A refill and an eject of the same coin in one cycle cancel; refills saturate.
    function automatic logic [3:0] update_count(input logic [3:0] cnt, input logic load, input logic take);
        logic [3:0] result;
        result = cnt;
        case ({load, take})
            2'b10:   result = (cnt == 4'd15) ? cnt : cnt + 4'd1;
            2'b01:   result = (cnt == 4'd0) ? cnt : cnt - 4'd1;
            default: result = cnt;
        endcase
        return result;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nickel_cnt <= 4'd0;
            dime_cnt   <= 4'd0;
        end else begin
            nickel_cnt <= update_count(nickel_cnt, bus.load_nickel, eject_nickel);
            dime_cnt   <= update_count(dime_cnt, bus.load_dime, eject_dime);
        end
    end

    assign bus.out_nickel = eject_nickel;
    assign bus.out_dime   = eject_dime;
    assign bus.nickel_cnt = nickel_cnt;
    assign bus.dime_cnt   = dime_cnt;
    assign bus.done       = (state == DONE);
    assign bus.err        = (state == FAULT);
    assign bus.busy       = (state != IDLE);
    assign bus.req_ready  = (state == IDLE);

endmodule
